nibble_serial_add_seq: RTL and testbench
========================================

// Module: nibble_serial_add_seq
// PURPOSE
//   Sequencer that wraps one external 4-bit ripple adder (fulladder_struct_four) to perform WIDTH-bit additions.
//   Accepts full-width operands over a valid/ready handshake.
//   Feeds one nibble per cycle, LSB nibble first, to the adder's A/B/Cin pins.
//   Consumes the adder's Sum/Cout, registers the carry between nibbles and assembles the full-width result.
//   Sits directly around the 4-bit adder: its fa_* outputs drive the adder, and the adder outputs return on fa_Sum/fa_Cout.
// PARAMETERS
//   WIDTH    16          operand/result width; must be a multiple of 4 and >= 4 (elaboration error otherwise)
//   NIBBLES  WIDTH/4     localparam, number of adder passes per operation
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   rst        in   1      synchronous, active-high reset
//   in_valid   in   1      operand request valid
//   in_ready   out  1      sequencer can accept operands
//   A          in   WIDTH  operand A, sampled on in_valid & in_ready
//   B          in   WIDTH  operand B, sampled on in_valid & in_ready
//   Cin        in   1      carry-in, sampled with A/B
//   fa_A       out  4      nibble of A to the 4-bit adder
//   fa_B       out  4      nibble of B to the 4-bit adder
//   fa_Cin     out  1      carry into the 4-bit adder
//   fa_Sum     in   4      4-bit adder sum (combinational return)
//   fa_Cout    in   1      4-bit adder carry-out (combinational return)
//   busy       out  1      high while an operation is in RUN
//   out_valid  out  1      result valid
//   out_ready  in   1      consumer accepts result
//   Sum        out  WIDTH  result, (A+B+Cin) mod 2^WIDTH
//   Cout       out  1      carry out of bit WIDTH-1
// BEHAVIOUR
//   FSM states: IDLE, RUN, DONE. Reset state is IDLE.
//   Reset values: out_valid=0, Sum=0, Cout=0, busy=0, nibble index=0, carry reg=0.
//   in_ready = (state==IDLE) & ~rst. fa_A, fa_B and fa_Cin are 0 outside RUN.
//   IDLE: on in_valid & in_ready, capture A, B and Cin into operand shift registers and the carry reg; idx<=0; go RUN.
//     While in_valid is low, remain in IDLE.
//   RUN, cycle k (k=0..NIBBLES-1):
//     fa_A = opA[3:0], fa_B = opB[3:0], fa_Cin = carry reg.
//     At the clock edge: result shifts right 4 with fa_Sum inserted at [WIDTH-1:WIDTH-4].
//     Also at the edge: carry <= fa_Cout; opA/opB shift right 4; idx++.
//     When k == NIBBLES-1: Sum <= final result, Cout <= fa_Cout, out_valid <= 1, go DONE.
//   Latency: out_valid rises exactly NIBBLES edges after the accepting edge (4 for WIDTH=16).
//   Throughput: one operation per NIBBLES+2 cycles minimum.
//   DONE: Sum, Cout and out_valid are held stable until out_valid & out_ready.
//     On that edge: out_valid <= 0; go IDLE. Sum/Cout keep their last value.
//   in_ready is low in RUN and DONE. in_valid in those states is ignored; operands are never re-sampled mid-operation.
//   busy = (state==RUN).
//   fa_Sum/fa_Cout are only sampled in RUN. Values outside RUN are don't-care.
//   Reset mid-operation (RUN or DONE): the operation is abandoned with no out_valid pulse.
//     All registers return to reset values on that edge.
//   Overflow: no saturation. The wrap goes to Sum; the carry goes to Cout.
// TESTING (WIDTH=16 unless noted, bench models the 4-bit adder behaviourally)
//   A=0x1234 B=0x4321 Cin=0 -> Sum=0x5555 Cout=0, out_valid 4 edges after accept, busy high 4 cycles
//   A=0xFFFF B=0x0000 Cin=1 -> carry ripples every nibble; Sum=0x0000 Cout=1; fa_Cin=1 in all 4 RUN cycles
//   A=0xFFFF B=0xFFFF Cin=1 -> Sum=0xFFFF Cout=1; check fa_A/fa_B = 0xF each RUN cycle, LSB nibble first
//   out_ready low 10 cycles in DONE with in_valid pulsing -> Sum/Cout/out_valid stable, in_ready=0, no capture
//   rst high during RUN cycle 2 -> next cycle out_valid=0, in_ready=1, fa_*=0.
//     Following op A=0x0001 B=0x0001 -> Sum=0x0002
//   1000 random ops, random in_valid/out_ready gaps, WIDTH=16 and WIDTH=4 -> Sum/Cout match A+B+Cin, in order

Source files
------------

// File: rtl/nibble_serial_add_seq.sv
// nibble_serial_add_seq: WIDTH-bit adder that sequences one external
// 4-bit adder a nibble per cycle, LSB first, with a registered carry.
module nibble_serial_add_seq #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  output logic [3:0]       fa_A,
  output logic [3:0]       fa_B,
  output logic             fa_Cin,
  input  logic [3:0]       fa_Sum,
  input  logic             fa_Cout,
  output logic             busy,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout
);

  localparam int NIBBLES = WIDTH / 4;
  localparam int IDXW = (NIBBLES > 1) ? $clog2(NIBBLES) : 1;

  if ((WIDTH % 4 != 0) || (WIDTH < 4)) begin : g_bad_width
    $error("WIDTH must be a multiple of 4 and >= 4");
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_opA;
  logic [WIDTH-1:0] r_opB;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [IDXW-1:0]  r_idx;

  logic             w_run;
  logic             w_last;
  logic [WIDTH-1:0] w_res_next;

  assign w_run  = (r_state == RUN);
  assign w_last = (r_idx == IDXW'(NIBBLES - 1));

  // new sum nibble enters at the top; after NIBBLES passes it is aligned
  assign w_res_next = (r_res >> 4)
                    | (WIDTH'(fa_Sum) << (WIDTH - 4));

  assign in_ready = (r_state == IDLE) & ~rst;
  assign busy     = w_run;
  assign fa_A     = w_run ? r_opA[3:0] : 4'h0;
  assign fa_B     = w_run ? r_opB[3:0] : 4'h0;
  assign fa_Cin   = w_run ? r_carry : 1'b0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_opA     <= '0;
      r_opB     <= '0;
      r_res     <= '0;
      r_carry   <= 1'b0;
      r_idx     <= '0;
      out_valid <= 1'b0;
      Sum       <= '0;
      Cout      <= 1'b0;
    end else begin
      unique case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_opA   <= A;
            r_opB   <= B;
            r_carry <= Cin;
            r_res   <= '0;
            r_idx   <= '0;
            r_state <= RUN;
          end
        end
        RUN: begin
          r_res   <= w_res_next;
          r_carry <= fa_Cout;
          r_opA   <= r_opA >> 4;
          r_opB   <= r_opB >> 4;
          r_idx   <= r_idx + 1'b1;
          if (w_last) begin
            Sum       <= w_res_next;
            Cout      <= fa_Cout;
            out_valid <= 1'b1;
            r_state   <= DONE;
          end
        end
        DONE: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            r_state   <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nibble_serial_add_seq.sv
// tb_nibble_serial_add_seq: directed and random checks of the nibble
// sequencer at WIDTH=16 and WIDTH=4 around a behavioural 4-bit adder.
module tb_nibble_serial_add_seq;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        in_valid, in_ready, Cin;
  logic [15:0] A, B, Sum;
  logic [3:0]  fa_A, fa_B, fa_Sum;
  logic        fa_Cin, fa_Cout;
  logic        busy, out_valid, out_ready, Cout;

  logic        q_in_valid, q_in_ready, q_Cin;
  logic [3:0]  q_A, q_B, q_Sum;
  logic [3:0]  q_fa_A, q_fa_B, q_fa_Sum;
  logic        q_fa_Cin, q_fa_Cout;
  logic        q_busy, q_out_valid, q_out_ready, q_Cout;

  assign {fa_Cout, fa_Sum} = 5'(fa_A) + 5'(fa_B) + 5'(fa_Cin);
  assign {q_fa_Cout, q_fa_Sum} = 5'(q_fa_A) + 5'(q_fa_B) + 5'(q_fa_Cin);

  nibble_serial_add_seq #(.WIDTH(16)) u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .A(A), .B(B), .Cin(Cin),
    .fa_A(fa_A), .fa_B(fa_B), .fa_Cin(fa_Cin),
    .fa_Sum(fa_Sum), .fa_Cout(fa_Cout),
    .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .Sum(Sum), .Cout(Cout)
  );

  nibble_serial_add_seq #(.WIDTH(4)) u_dut4 (
    .clk(clk), .rst(rst),
    .in_valid(q_in_valid), .in_ready(q_in_ready),
    .A(q_A), .B(q_B), .Cin(q_Cin),
    .fa_A(q_fa_A), .fa_B(q_fa_B), .fa_Cin(q_fa_Cin),
    .fa_Sum(q_fa_Sum), .fa_Cout(q_fa_Cout),
    .busy(q_busy), .out_valid(q_out_valid), .out_ready(q_out_ready),
    .Sum(q_Sum), .Cout(q_Cout)
  );

  int n_chk = 0;
  int n_err = 0;

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic retire16();
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    #1;
    chk("ret_ov", 32'(out_valid), 0);
    chk("ret_rdy", 32'(in_ready), 1);
  endtask

  // accept one op and follow it nibble by nibble through RUN
  task automatic dir_op(input logic [15:0] a, input logic [15:0] b,
                        input logic c, input logic [15:0] es,
                        input logic ec, input logic retire);
    logic       cy;
    logic [4:0] t;
    @(negedge clk);
    A = a; B = b; Cin = c; in_valid = 1'b1;
    #1 chk("acc_rdy", 32'(in_ready), 1);
    @(negedge clk);
    in_valid = 1'b0; A = '0; B = '0; Cin = 1'b0;
    cy = c;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("run_busy", 32'(busy), 1);
      chk("run_ov", 32'(out_valid), 0);
      chk("run_rdy", 32'(in_ready), 0);
      chk("fa_A", 32'(fa_A), 32'(a[4*k+:4]));
      chk("fa_B", 32'(fa_B), 32'(b[4*k+:4]));
      chk("fa_Cin", 32'(fa_Cin), 32'(cy));
      t = 5'(a[4*k+:4]) + 5'(b[4*k+:4]) + 5'(cy);
      cy = t[4];
      @(negedge clk);
    end
    #1;
    chk("done_ov", 32'(out_valid), 1);
    chk("done_sum", 32'(Sum), 32'(es));
    chk("done_cout", 32'(Cout), 32'(ec));
    chk("done_busy", 32'(busy), 0);
    chk("done_fa", 32'({fa_A, fa_B, fa_Cin}), 0);
    if (retire) retire16();
  endtask

  task automatic rnd16();
    logic [15:0] a, b;
    logic        c;
    logic [16:0] e;
    int          n;
    a = 16'($urandom); b = 16'($urandom); c = 1'($urandom);
    e = 17'(a) + 17'(b) + 17'(c);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    A = a; B = b; Cin = c; in_valid = 1'b1;
    n = 0;
    #1;
    while (!in_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!in_ready) begin chk("r16_tmo_in", 0, 1); in_valid = 1'b0; return; end
    @(negedge clk);
    in_valid = 1'b0; A = $urandom; B = $urandom;
    n = 0;
    #1;
    while (!out_valid && n < 20) begin @(negedge clk); #1; n++; end
    if (!out_valid) begin chk("r16_tmo_out", 0, 1); return; end
    repeat ($urandom_range(0, 2)) @(negedge clk);
    #1 chk("r16_res", 32'({Cout, Sum}), 32'(e));
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  task automatic rnd4();
    logic [3:0] a, b;
    logic       c;
    logic [4:0] e;
    int         n;
    a = 4'($urandom); b = 4'($urandom); c = 1'($urandom);
    e = 5'(a) + 5'(b) + 5'(c);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    q_A = a; q_B = b; q_Cin = c; q_in_valid = 1'b1;
    n = 0;
    #1;
    while (!q_in_ready && n < 20) begin @(negedge clk); #1; n++; end
    if (!q_in_ready) begin chk("r4_tmo_in", 0, 1); q_in_valid = 1'b0; return; end
    @(negedge clk);
    q_in_valid = 1'b0; q_A = 4'($urandom); q_B = 4'($urandom);
    #1 chk("r4_lat_ov", 32'(q_out_valid), 0);
    @(negedge clk);
    #1 chk("r4_lat_ov1", 32'(q_out_valid), 1);
    repeat ($urandom_range(0, 2)) @(negedge clk);
    #1 chk("r4_res", 32'({q_Cout, q_Sum}), 32'(e));
    q_out_ready = 1'b1;
    @(negedge clk);
    q_out_ready = 1'b0;
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; out_ready = 1'b0;
    A = '0; B = '0; Cin = 1'b0;
    q_in_valid = 1'b0; q_out_ready = 1'b0;
    q_A = '0; q_B = '0; q_Cin = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("rst_rdy_low", 32'(in_ready), 0);
    rst = 1'b0;
    #1;
    chk("rst_rdy", 32'(in_ready), 1);
    chk("rst_ov", 32'(out_valid), 0);
    chk("rst_sum", 32'({Cout, Sum}), 0);
    chk("rst_busy", 32'(busy), 0);
    chk("rst_fa", 32'({fa_A, fa_B, fa_Cin}), 0);
    chk("rst_q_rdy", 32'(q_in_ready), 1);

    dir_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b1);
    dir_op(16'hFFFF, 16'h0000, 1'b1, 16'h0000, 1'b1, 1'b1);
    dir_op(16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b1);
    dir_op(16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1);

    // consumer stalls in DONE while new requests knock
    dir_op(16'h1234, 16'h4321, 1'b0, 16'h5555, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      in_valid = 1'(i);
      A = 16'($urandom); B = 16'($urandom); Cin = 1'(i);
      @(negedge clk);
      #1;
      chk("hold_ov", 32'(out_valid), 1);
      chk("hold_sum", 32'({Cout, Sum}), 32'h05555);
      chk("hold_rdy", 32'(in_ready), 0);
      chk("hold_busy", 32'(busy), 0);
    end
    in_valid = 1'b0;
    retire16();
    @(negedge clk);
    #1 chk("no_capture", 32'(busy), 0);

    // reset lands during RUN cycle 2
    @(negedge clk);
    A = 16'h1234; B = 16'h4321; Cin = 1'b0; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (2) @(negedge clk);
    #1 chk("pre_rst_busy", 32'(busy), 1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ov", 32'(out_valid), 0);
    chk("mid_rst_rdy", 32'(in_ready), 1);
    chk("mid_rst_fa", 32'({fa_A, fa_B, fa_Cin}), 0);
    chk("mid_rst_sum", 32'({Cout, Sum}), 0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      #1 chk("mid_rst_noov", 32'(out_valid), 0);
    end
    dir_op(16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b1);

    for (int i = 0; i < 1000; i++) rnd16();
    for (int i = 0; i < 1000; i++) rnd4();

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
